// File: rtl/ram_arb_pkg.sv
// Shared types and sizes for the data RAM and the blocks that access it.
package ram_arb_pkg;
    typedef enum logic [1:0] {ARB_IDLE, ARB_OWN0, ARB_OWN1} arb_state_t;
    localparam int RAM_ADDR_W = 7;
    localparam int RAM_DATA_W = 8;
endpackage

// File: rtl/ram_arbiter.sv
// Shares the single-port data RAM between the CPU data port (0) and the debug/DMA port (1):
// round-robin on ties, bounded bursts, one access per cycle, read data one cycle after grant.
module ram_arbiter
    import ram_arb_pkg::*;
#(
    parameter int ADDR_W    = RAM_ADDR_W,
    parameter int DATA_W    = RAM_DATA_W,
    parameter int BURST_MAX = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0,
    input  logic              we0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] wdata0,
    input  logic              req1,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              rvalid0,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata,
    output logic              ram_en,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_data,
    input  logic [DATA_W-1:0] ram_q
);

    localparam logic [3:0] BURST_MAX_C = 4'(BURST_MAX);

    arb_state_t        r_state;
    arb_state_t        w_state_next;
    logic              r_last;
    logic [3:0]        r_cnt;
    logic [3:0]        w_cnt_next;
    logic [3:0]        w_cnt_inc;
    logic              w_gnt0_raw;
    logic              w_gnt1_raw;
    logic              w_gnt0;
    logic              w_gnt1;
    logic              r_rvalid0;
    logic              r_rvalid1;
    logic [DATA_W-1:0] r_rdata;

    always_comb begin
        w_gnt0_raw   = 1'b0;
        w_gnt1_raw   = 1'b0;
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        // cnt saturates at the burst limit while the owner runs unopposed
        w_cnt_inc    = (r_cnt < BURST_MAX_C) ? r_cnt + 4'd1 : BURST_MAX_C;
        case (r_state)
            ARB_IDLE: begin
                if (req0 && (!req1 || r_last)) begin
                    w_gnt0_raw   = 1'b1;
                    w_state_next = ARB_OWN0;
                    w_cnt_next   = 4'd1;
                end else if (req1) begin
                    w_gnt1_raw   = 1'b1;
                    w_state_next = ARB_OWN1;
                    w_cnt_next   = 4'd1;
                end else begin
                    w_cnt_next   = 4'd0;
                end
            end
            ARB_OWN0: begin
                if (req0 && ((r_cnt < BURST_MAX_C) || !req1)) begin
                    w_gnt0_raw   = 1'b1;
                    w_cnt_next   = w_cnt_inc;
                end else if (req1) begin
                    w_gnt1_raw   = 1'b1;
                    w_state_next = ARB_OWN1;
                    w_cnt_next   = 4'd1;
                end else begin
                    w_state_next = ARB_IDLE;
                    w_cnt_next   = 4'd0;
                end
            end
            ARB_OWN1: begin
                if (req1 && ((r_cnt < BURST_MAX_C) || !req0)) begin
                    w_gnt1_raw   = 1'b1;
                    w_cnt_next   = w_cnt_inc;
                end else if (req0) begin
                    w_gnt0_raw   = 1'b1;
                    w_state_next = ARB_OWN0;
                    w_cnt_next   = 4'd1;
                end else begin
                    w_state_next = ARB_IDLE;
                    w_cnt_next   = 4'd0;
                end
            end
            default: begin
                w_state_next = ARB_IDLE;
                w_cnt_next   = 4'd0;
            end
        endcase
    end

    // No access may reach the RAM while reset is asserted
    assign w_gnt0   = w_gnt0_raw & ~reset;
    assign w_gnt1   = w_gnt1_raw & ~reset;
    assign gnt0     = w_gnt0;
    assign gnt1     = w_gnt1;
    assign ram_en   = (w_gnt0 & we0) | (w_gnt1 & we1);
    assign ram_addr = w_gnt1 ? addr1 : addr0;
    assign ram_data = w_gnt1 ? wdata1 : wdata0;
    assign rvalid0  = r_rvalid0;
    assign rvalid1  = r_rvalid1;
    assign rdata    = r_rdata;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= ARB_IDLE;
            r_last    <= 1'b1;
            r_cnt     <= 4'd0;
            r_rvalid0 <= 1'b0;
            r_rvalid1 <= 1'b0;
            r_rdata   <= '0;
        end else begin
            r_state   <= w_state_next;
            r_cnt     <= w_cnt_next;
            if (w_gnt0) begin
                r_last <= 1'b0;
            end else if (w_gnt1) begin
                r_last <= 1'b1;
            end
            r_rvalid0 <= w_gnt0 & ~we0;
            r_rvalid1 <= w_gnt1 & ~we1;
            if ((w_gnt0 & ~we0) | (w_gnt1 & ~we1)) begin
                r_rdata <= ram_q;
            end
        end
    end

endmodule
